core_host_driver: RTL

Host-side driver for the accelerator core's testbench-facing memory interface.
- Takes a start command and an input word stream.
- Writes activations into the x bank, then weights into the w bank.
- Triggers mem_load_complete, waits for convolution_complete, then reads all len_onij psum rows back and emits them as a backpressured output stream.
- Replaces the hand-written testbench sequencer, so the core can be driven by a DMA/host fabric.

---
 rtl/core_host_pkg.sv | 16 +
 rtl/core_host_rdbuf.sv | 37 +++
 rtl/core_host_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/core_host_pkg.sv
// core_host_pkg: shared state encoding and default widths for the core host driver.
// Ports: none (package).
package core_host_pkg;
   localparam int BW = 4;
   localparam int PSUM_BW = 16;
   localparam int ROW = 8;
   localparam int COL = 8;
   localparam int ADDR_WIDTH = 8;
   localparam int LEN_ONIJ = 16;
   localparam int RD_LAT = 1;
   localparam int TIMEOUT = 65535;
   localparam int IN_W = BW * ROW;
   localparam int OUT_W = PSUM_BW * COL;
   localparam int CNT_W = ADDR_WIDTH + 1;
   typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, KICK, WAIT, READ, DRAIN, DONE} state_t;
endpackage

// File: rtl/core_host_rdbuf.sv
// core_host_rdbuf: small synchronous FIFO with occupancy count, holds psum rows read back from the core.
// Ports: clk/reset (async active-low), push+din write side, pop+dout read side (dout = head), count = occupancy.
module core_host_rdbuf #(
   parameter int W = 8,
   parameter int D = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic [$clog2(D+1)-1:0]   count
);
   localparam int AW = (D > 1) ? $clog2(D) : 1;
   localparam int FW = $clog2(D + 1);
   logic [W-1:0] mem [D];
   logic [AW-1:0] wp, rp;
   logic pop_ok;
   assign pop_ok = pop && (count != '0);
   assign dout = mem[rp];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
         for (int i = 0; i < D; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp <= (wp == AW'(D - 1)) ? '0 : wp + 1'b1;
         end
         if (pop_ok) rp <= (rp == AW'(D - 1)) ? '0 : rp + 1'b1;
         count <= count + FW'(push) - FW'(pop_ok);
      end
   end
endmodule

// File: rtl/core_host_driver.sv
// core_host_driver: sequences x/w loads into the core, kicks the convolution and streams the psum rows back out.
// Ports: start_i/mode_i/num_x_i/num_w_i command, busy_o/done_o/err_o status,
//        s_* input word stream, m_* psum row stream, remaining ports drive/observe the core memory interface.
module core_host_driver
   import core_host_pkg::*;
#(
   parameter int bw = BW,
   parameter int psum_bw = PSUM_BW,
   parameter int row = ROW,
   parameter int col = COL,
   parameter int addr_width = ADDR_WIDTH,
   parameter int len_onij = LEN_ONIJ,
   parameter int rd_lat = RD_LAT,
   parameter int timeout = TIMEOUT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start_i,
   input  logic                      mode_i,
   input  logic [addr_width:0]       num_x_i,
   input  logic [addr_width:0]       num_w_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   input  logic                      s_valid_i,
   output logic                      s_ready_o,
   input  logic [bw*row-1:0]         s_data_i,
   output logic                      m_valid_o,
   input  logic                      m_ready_i,
   output logic [psum_bw*col-1:0]    m_data_o,
   output logic                      execution_mode,
   output logic [addr_width-1:0]     ADDR,
   output logic                      ibank_selection,
   output logic                      WEN,
   output logic                      CEN,
   output logic [bw*row-1:0]         data_in,
   output logic                      mem_load_complete,
   input  logic                      convolution_complete,
   input  logic [psum_bw*col-1:0]    data_out
);
   localparam int OW = psum_bw * col;
   localparam int CW = addr_width + 1;
   localparam int D = rd_lat + 2;
   localparam int FW = $clog2(D + 1);
   localparam int RW = $clog2(len_onij + 1);
   localparam int TW = $clog2(timeout + 1);
   state_t state;
   logic [CW-1:0] nx, nw, idx;
   logic [RW-1:0] rd_idx;
   logic [TW-1:0] wait_cnt;
   logic [rd_lat:0] rv;
   logic [FW-1:0] count;
   logic issue, last_w, last_r, pop;
   function automatic logic [CW-1:0] clamp(input logic [CW-1:0] n);
      return (n[CW-1] && |n[CW-2:0]) ? {1'b1, {(CW-1){1'b0}}} : n;
   endfunction
   assign last_w = (idx + 1'b1) == (state == LOAD_X ? nx : nw);
   assign last_r = rd_idx == RW'(len_onij - 1);
   // rv[0] marks a read command at the pins, rv[rd_lat] marks its data on data_out.
   // Every in-flight read must find a free slot, so the buffer can never overflow.
   assign issue = (state == READ) && (int'(count) + $countones(rv) < D);
   assign m_valid_o = count != '0;
   assign pop = m_valid_o & m_ready_i;
   core_host_rdbuf #(.W(OW), .D(D)) u_rdbuf (
      .clk(clk), .reset(reset), .push(rv[rd_lat]), .din(data_out),
      .pop(pop), .dout(m_data_o), .count(count)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         CEN <= 1'b1;
         WEN <= 1'b1;
         ibank_selection <= 1'b0;
         ADDR <= '0;
         data_in <= '0;
         mem_load_complete <= 1'b0;
         execution_mode <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         err_o <= 1'b0;
         s_ready_o <= 1'b0;
         nx <= '0;
         nw <= '0;
         idx <= '0;
         rd_idx <= '0;
         wait_cnt <= '0;
         rv <= '0;
      end else begin
         CEN <= 1'b1;
         WEN <= 1'b1;
         done_o <= 1'b0;
         rv <= {rv[rd_lat-1:0], issue};
         case (state)
            IDLE: if (start_i) begin
               execution_mode <= mode_i;
               nx <= clamp(num_x_i);
               nw <= clamp(num_w_i);
               err_o <= 1'b0;
               busy_o <= 1'b1;
               idx <= '0;
               rd_idx <= '0;
               wait_cnt <= '0;
               s_ready_o <= |{num_x_i, num_w_i};
               state <= (num_x_i != '0) ? LOAD_X : (num_w_i != '0) ? LOAD_W : KICK;
            end
            LOAD_X, LOAD_W: if (s_valid_i && s_ready_o) begin
               CEN <= 1'b0;
               WEN <= 1'b0;
               ADDR <= idx[addr_width-1:0];
               data_in <= s_data_i;
               ibank_selection <= state == LOAD_W;
               idx <= last_w ? '0 : idx + 1'b1;
               if (last_w && state == LOAD_X && nw != '0) state <= LOAD_W;
               else if (last_w) begin
                  state <= KICK;
                  s_ready_o <= 1'b0;
               end
            end
            KICK: begin
               mem_load_complete <= 1'b1;
               state <= WAIT;
            end
            WAIT: if (convolution_complete) begin
               mem_load_complete <= 1'b0;
               state <= READ;
            end else if (wait_cnt == TW'(timeout - 1)) begin
               err_o <= 1'b1;
               mem_load_complete <= 1'b0;
               done_o <= 1'b1;
               state <= DONE;
            end else wait_cnt <= wait_cnt + 1'b1;
            READ: if (issue) begin
               CEN <= 1'b0;
               ibank_selection <= 1'b0;
               ADDR <= addr_width'(rd_idx);
               rd_idx <= rd_idx + 1'b1;
               if (last_r) state <= DRAIN;
            end
            DRAIN: if (count == '0 && rv == '0) begin
               done_o <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy_o <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
